dma_slave_memory: RTL and testbench

- Avalon-MM 16-bit responder memory for the video DMA path. It is the slave-side counterpart to the engine's read master (mr_*) and write master (mw_*).
- Provides one read-only slave port and one write-only slave port over a shared on-chip RAM.
- Wait states are programmable. Read data is valid in the same cycle waitrequest drops, matching a master that captures data on ~waitrequest.
- Out-of-range and misaligned accesses are flagged in sticky error status.

---
 rtl/dma_slave_memory_pkg.sv | 26 ++
 rtl/dma_sdp_ram.sv | 31 +++
 rtl/dma_slave_memory.sv | 197 +++++++++++++++++++
 tb/tb_dma_slave_memory.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dma_slave_memory_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dma_slave_memory_pkg                                                       |
// | Shared state encodings and constants for the DMA slave memory.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package dma_slave_memory_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RAM  = 2'd2,
        R_ACK  = 2'd3
    } read_state_t;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_WAIT   = 2'd1,
        W_COMMIT = 2'd2
    } write_state_t;

    localparam logic [15:0] BAD_READ_DATA  = 16'hDEAD;
    localparam int          WAIT_CNT_WIDTH = 4;

endpackage
`default_nettype wire

// File: rtl/dma_sdp_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dma_sdp_ram                                                                |
// | Simple dual-port 16-bit RAM, byte-lane writes, registered read.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dma_sdp_ram #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [1:0]            wr_byteenable,
    input  logic [15:0]           wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [15:0]           rd_data
);

    logic [15:0] r_mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (wr_en && wr_byteenable[i]) begin
                r_mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
        rd_data <= r_mem[rd_addr];
    end

endmodule
`default_nettype wire

// File: rtl/dma_slave_memory.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dma_slave_memory                                                           |
// | Avalon-MM read/write responder over a shared RAM with sticky error status. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dma_slave_memory
    import dma_slave_memory_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned WAIT_STATES  = 1,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        clock_sreset_n,
    input  logic [31:0] r_address,
    input  logic [1:0]  r_byteenable,
    input  logic        r_read,
    output logic [15:0] r_readdata,
    output logic        r_waitrequest,
    input  logic [31:0] w_address,
    input  logic [1:0]  w_byteenable,
    input  logic [15:0] w_writedata,
    input  logic        w_write,
    output logic        w_waitrequest,
    input  logic        err_clear,
    output logic        err_flag,
    output logic [31:0] err_address
);

    localparam bit c_has_wait = (WAIT_STATES > 0);
    localparam logic [WAIT_CNT_WIDTH-1:0] c_last_wait =
        WAIT_CNT_WIDTH'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    function automatic logic decode_bad(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDRESS;
        return (addr < BASE_ADDRESS) || off[0] || ((off >> (ADDR_WIDTH + 1)) != 32'd0);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] decode_index(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDRESS;
        return off[ADDR_WIDTH:1];
    endfunction

    read_state_t               r_rd_state, w_rd_next;
    logic [WAIT_CNT_WIDTH-1:0] r_rd_cnt;
    logic [ADDR_WIDTH-1:0]     r_rd_index;
    logic                      r_rd_bad;
    logic [31:0]               r_rd_raw;
    logic [15:0]               r_rd_hold;

    write_state_t              r_wr_state, w_wr_next;
    logic [WAIT_CNT_WIDTH-1:0] r_wr_cnt;
    logic [ADDR_WIDTH-1:0]     r_wr_index;
    logic                      r_wr_bad;
    logic [31:0]               r_wr_raw;
    logic [15:0]               r_wr_data;
    logic [1:0]                r_wr_be;

    logic                      r_byp_valid;
    logic [1:0]                r_byp_be;
    logic [15:0]               r_byp_data;

    logic [15:0] w_ram_rd;
    logic [15:0] w_merged;
    logic [15:0] w_ack_data;
    logic        w_ram_we;
    logic        w_collide;
    logic        w_rd_err;
    logic        w_wr_err;
    logic        r_err_flag;
    logic [31:0] r_err_address;
    logic        w_unused_ok;

    assign w_unused_ok = ^r_byteenable;

    always_ff @(posedge clock) begin
        if (!clock_sreset_n) begin
            r_rd_state <= R_IDLE;
            r_wr_state <= W_IDLE;
        end else begin
            r_rd_state <= w_rd_next;
            r_wr_state <= w_wr_next;
        end
    end

    always_comb begin
        w_rd_next     = r_rd_state;
        r_waitrequest = r_read && (r_rd_state != R_ACK);
        case (r_rd_state)
            R_IDLE:  if (r_read) w_rd_next = c_has_wait ? R_WAIT : R_RAM;
            R_WAIT:  if (!r_read) w_rd_next = R_IDLE;
                     else if (r_rd_cnt == c_last_wait) w_rd_next = R_RAM;
            R_RAM:   w_rd_next = r_read ? R_ACK : R_IDLE;
            R_ACK:   w_rd_next = R_IDLE;
            default: w_rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_wr_next     = r_wr_state;
        w_waitrequest = w_write && (r_wr_state != W_COMMIT);
        case (r_wr_state)
            W_IDLE:   if (w_write) w_wr_next = c_has_wait ? W_WAIT : W_COMMIT;
            W_WAIT:   if (!w_write) w_wr_next = W_IDLE;
                      else if (r_wr_cnt == c_last_wait) w_wr_next = W_COMMIT;
            W_COMMIT: w_wr_next = W_IDLE;
            default:  w_wr_next = W_IDLE;
        endcase
    end

    // Request capture and wait counting; no reset needed, state gates their use.
    always_ff @(posedge clock) begin
        if (r_rd_state == R_IDLE && r_read) begin
            r_rd_index <= decode_index(r_address);
            r_rd_bad   <= decode_bad(r_address);
            r_rd_raw   <= r_address;
            r_rd_cnt   <= '0;
        end else if (r_rd_state == R_WAIT) begin
            r_rd_cnt   <= r_rd_cnt + 1'b1;
        end
        if (r_wr_state == W_IDLE && w_write) begin
            r_wr_index <= decode_index(w_address);
            r_wr_bad   <= decode_bad(w_address);
            r_wr_raw   <= w_address;
            r_wr_data  <= w_writedata;
            r_wr_be    <= w_byteenable;
            r_wr_cnt   <= '0;
        end else if (r_wr_state == W_WAIT) begin
            r_wr_cnt   <= r_wr_cnt + 1'b1;
        end
        r_byp_valid <= w_collide;
        r_byp_be    <= r_wr_be;
        r_byp_data  <= r_wr_data;
    end

    // Reset must suppress a commit that coincides with it.
    assign w_ram_we  = (r_wr_state == W_COMMIT) && !r_wr_bad && clock_sreset_n;
    assign w_collide = (r_rd_state == R_RAM) && (r_wr_state == W_COMMIT) &&
                       (r_rd_index == r_wr_index) && !r_wr_bad;

    dma_sdp_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clock         (clock),
        .wr_en         (w_ram_we),
        .wr_addr       (r_wr_index),
        .wr_byteenable (r_wr_be),
        .wr_data       (r_wr_data),
        .rd_addr       (r_rd_index),
        .rd_data       (w_ram_rd)
    );

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_merged[i*8 +: 8] = (r_byp_valid && r_byp_be[i]) ? r_byp_data[i*8 +: 8]
                                                               : w_ram_rd[i*8 +: 8];
        end
    end

    assign w_ack_data = r_rd_bad ? BAD_READ_DATA : w_merged;
    assign r_readdata = (r_rd_state == R_ACK) ? w_ack_data : r_rd_hold;

    always_ff @(posedge clock) begin
        if (!clock_sreset_n) begin
            r_rd_hold <= 16'h0;
        end else if (r_rd_state == R_ACK) begin
            r_rd_hold <= w_ack_data;
        end
    end

    assign w_rd_err = (r_rd_state == R_ACK) && r_rd_bad;
    assign w_wr_err = (r_wr_state == W_COMMIT) && r_wr_bad;

    // A new error beats err_clear; the write address wins a same-cycle tie.
    always_ff @(posedge clock) begin
        if (!clock_sreset_n) begin
            r_err_flag    <= 1'b0;
            r_err_address <= 32'h0;
        end else if (w_rd_err || w_wr_err) begin
            r_err_flag <= 1'b1;
            if (!r_err_flag || err_clear) begin
                r_err_address <= w_wr_err ? r_wr_raw : r_rd_raw;
            end
        end else if (err_clear) begin
            r_err_flag    <= 1'b0;
            r_err_address <= 32'h0;
        end
    end

    assign err_flag    = r_err_flag;
    assign err_address = r_err_address;

endmodule
`default_nettype wire

// File: tb/tb_dma_slave_memory.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dma_slave_memory                                                        |
// | Directed vector bench: one instance with 0 and one with 1 wait state.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dma_slave_memory;

    logic        clock = 1'b0;
    logic        rst_n;
    logic [31:0] r_address     [2];
    logic [1:0]  r_byteenable  [2];
    logic        r_read        [2];
    logic [15:0] r_readdata    [2];
    logic        r_waitrequest [2];
    logic [31:0] w_address     [2];
    logic [1:0]  w_byteenable  [2];
    logic [15:0] w_writedata   [2];
    logic        w_write       [2];
    logic        w_waitrequest [2];
    logic        err_clear     [2];
    logic        err_flag      [2];
    logic [31:0] err_address   [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    dma_slave_memory #(.ADDR_WIDTH(12), .WAIT_STATES(0), .BASE_ADDRESS(32'h0)) u_ws0 (
        .clock(clock), .clock_sreset_n(rst_n),
        .r_address(r_address[0]), .r_byteenable(r_byteenable[0]), .r_read(r_read[0]),
        .r_readdata(r_readdata[0]), .r_waitrequest(r_waitrequest[0]),
        .w_address(w_address[0]), .w_byteenable(w_byteenable[0]), .w_writedata(w_writedata[0]),
        .w_write(w_write[0]), .w_waitrequest(w_waitrequest[0]),
        .err_clear(err_clear[0]), .err_flag(err_flag[0]), .err_address(err_address[0])
    );

    dma_slave_memory #(.ADDR_WIDTH(12), .WAIT_STATES(1), .BASE_ADDRESS(32'h0)) u_ws1 (
        .clock(clock), .clock_sreset_n(rst_n),
        .r_address(r_address[1]), .r_byteenable(r_byteenable[1]), .r_read(r_read[1]),
        .r_readdata(r_readdata[1]), .r_waitrequest(r_waitrequest[1]),
        .w_address(w_address[1]), .w_byteenable(w_byteenable[1]), .w_writedata(w_writedata[1]),
        .w_write(w_write[1]), .w_waitrequest(w_waitrequest[1]),
        .err_clear(err_clear[1]), .err_flag(err_flag[1]), .err_address(err_address[1])
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
        logic [15:0] exp;
        int          lat;
        logic        ef;
        logic [31:0] ea;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Latency counts cycles from the sampling IDLE cycle to the one with waitrequest low.
    task automatic do_read(input int d, input logic [31:0] addr,
                           output logic [15:0] data, output int lat);
        r_address[d] = addr; r_byteenable[d] = 2'b11; r_read[d] = 1'b1;
        lat = 0; data = 'x;
        forever begin
            #1;
            if (!r_waitrequest[d]) begin data = r_readdata[d]; break; end
            if (lat >= 40) break;
            @(posedge clock); #1; lat++;
        end
        @(posedge clock); #1;
        r_read[d] = 1'b0;
    endtask

    task automatic do_write(input int d, input logic [31:0] addr, input logic [15:0] data,
                            input logic [1:0] be, output int lat);
        w_address[d] = addr; w_writedata[d] = data; w_byteenable[d] = be; w_write[d] = 1'b1;
        lat = 0;
        forever begin
            #1;
            if (!w_waitrequest[d]) break;
            if (lat >= 40) break;
            @(posedge clock); #1; lat++;
        end
        @(posedge clock); #1;
        w_write[d] = 1'b0;
    endtask

    task automatic write_then_reset(input int n);
        w_address[1] = 32'h30; w_writedata[1] = 16'h9999; w_byteenable[1] = 2'b11; w_write[1] = 1'b1;
        repeat (n) begin @(posedge clock); #1; end
        rst_n = 1'b0;
        @(posedge clock); #1;
        w_write[1] = 1'b0; rst_n = 1'b1;
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] rd;
        int          lat, lat2;
        logic [15:0] src [4];

        for (int d = 0; d < 2; d++) begin
            r_address[d] = '0; r_byteenable[d] = '0; r_read[d] = 1'b0;
            w_address[d] = '0; w_byteenable[d] = '0; w_writedata[d] = '0; w_write[d] = 1'b0;
            err_clear[d] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst%0d readdata", d), r_readdata[d], 16'h0);
            check($sformatf("rst%0d err_flag", d), err_flag[d], 1'b0);
            check($sformatf("rst%0d err_address", d), err_address[d], 32'h0);
            check($sformatf("rst%0d r_waitrequest", d), r_waitrequest[d], 1'b0);
            check($sformatf("rst%0d w_waitrequest", d), w_waitrequest[d], 1'b0);
        end
        rst_n = 1'b1;
        @(posedge clock); #1;

        // wr, addr, data, be, expected read, latency, err_flag, err_address
        vt.push_back('{1'b1, 32'h10,   16'h1234, 2'b11, 16'h0,    2, 1'b0, 32'h0});
        vt.push_back('{1'b0, 32'h10,   16'h0,    2'b11, 16'h1234, 3, 1'b0, 32'h0});
        vt.push_back('{1'b1, 32'h20,   16'hAAAA, 2'b11, 16'h0,    2, 1'b0, 32'h0});
        vt.push_back('{1'b1, 32'h20,   16'h5566, 2'b01, 16'h0,    2, 1'b0, 32'h0});
        vt.push_back('{1'b0, 32'h20,   16'h0,    2'b11, 16'hAA66, 3, 1'b0, 32'h0});
        vt.push_back('{1'b1, 32'h0,    16'h0F0F, 2'b11, 16'h0,    2, 1'b0, 32'h0});
        vt.push_back('{1'b0, 32'h2001, 16'h0,    2'b11, 16'hDEAD, 3, 1'b1, 32'h2001});
        vt.push_back('{1'b1, 32'h2000, 16'h7777, 2'b11, 16'h0,    2, 1'b1, 32'h2001});
        vt.push_back('{1'b0, 32'h0,    16'h0,    2'b11, 16'h0F0F, 3, 1'b1, 32'h2001});
        vt.push_back('{1'b0, 32'h11,   16'h0,    2'b11, 16'hDEAD, 3, 1'b1, 32'h2001});
        vt.push_back('{1'b1, 32'h40,   16'h0000, 2'b11, 16'h0,    2, 1'b1, 32'h2001});
        vt.push_back('{1'b1, 32'h30,   16'h1111, 2'b11, 16'h0,    2, 1'b1, 32'h2001});

        foreach (vt[i]) begin
            if (vt[i].wr) begin
                do_write(1, vt[i].addr, vt[i].data, vt[i].be, lat);
            end else begin
                do_read(1, vt[i].addr, rd, lat);
                check($sformatf("v%0d readdata", i), rd, vt[i].exp);
            end
            check($sformatf("v%0d latency", i), lat, vt[i].lat);
            check($sformatf("v%0d err_flag", i), err_flag[1], vt[i].ef);
            check($sformatf("v%0d err_address", i), err_address[1], vt[i].ea);
        end

        err_clear[1] = 1'b1;
        @(posedge clock); #1;
        err_clear[1] = 1'b0;
        check("clear err_flag", err_flag[1], 1'b0);
        check("clear err_address", err_address[1], 32'h0);

        // Both start together so the commit lands in the read's RAM cycle.
        fork
            do_read(1, 32'h40, rd, lat);
            do_write(1, 32'h40, 16'hBEEF, 2'b10, lat2);
        join
        check("collide readdata", rd, 16'hBE00);
        check("collide read latency", lat, 3);
        check("collide write latency", lat2, 2);
        do_read(1, 32'h40, rd, lat);
        check("collide ram", rd, 16'hBE00);

        fork
            do_read(1, 32'h10, rd, lat);
            do_write(1, 32'h50, 16'h4242, 2'b11, lat2);
        join
        check("indep readdata", rd, 16'h1234);
        check("indep read latency", lat, 3);
        check("indep write latency", lat2, 2);
        do_read(1, 32'h50, rd, lat);
        check("indep ram", rd, 16'h4242);

        w_address[1] = 32'h10; w_writedata[1] = 16'hFFFF; w_byteenable[1] = 2'b11; w_write[1] = 1'b1;
        @(posedge clock); #1;
        check("withdraw waitrequest", w_waitrequest[1], 1'b1);
        w_write[1] = 1'b0;
        @(posedge clock); #1;
        do_read(1, 32'h10, rd, lat);
        check("withdraw ram", rd, 16'h1234);
        check("withdraw err_flag", err_flag[1], 1'b0);

        for (int n = 1; n <= 2; n++) begin
            write_then_reset(n);
            check($sformatf("rstw%0d readdata", n), r_readdata[1], 16'h0);
            check($sformatf("rstw%0d w_waitrequest", n), w_waitrequest[1], 1'b0);
            check($sformatf("rstw%0d r_waitrequest", n), r_waitrequest[1], 1'b0);
            do_read(1, 32'h30, rd, lat);
            check($sformatf("rstw%0d ram", n), rd, 16'h1111);
            check($sformatf("rstw%0d latency", n), lat, 3);
        end

        src[0] = 16'h0101; src[1] = 16'h2323; src[2] = 16'h4545; src[3] = 16'h6767;
        for (int i = 0; i < 4; i++) begin
            do_write(0, 32'(2 * i), src[i], 2'b11, lat);
            check($sformatf("fill%0d latency", i), lat, 1);
        end
        for (int i = 0; i < 4; i++) begin
            do_read(0, 32'(2 * i), rd, lat);
            check($sformatf("copy%0d read latency", i), lat, 2);
            check($sformatf("copy%0d read data", i), rd, src[i]);
            do_write(0, 32'h100 + 32'(2 * i), rd, 2'b11, lat);
            check($sformatf("copy%0d write latency", i), lat, 1);
        end
        for (int i = 0; i < 4; i++) begin
            do_read(0, 32'h100 + 32'(2 * i), rd, lat);
            check($sformatf("dest%0d data", i), rd, src[i]);
        end
        check("copy err_flag", err_flag[0], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
